// File: rtl/alu_pkg.sv
// Shared ALU definitions: result source tags (ALU_FUN[3:2] order) and entry sizing.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic [1:0] TAG_ARITH = 2'b00;
  localparam logic [1:0] TAG_LOGIC = 2'b01;
  localparam logic [1:0] TAG_CMP   = 2'b10;
  localparam logic [1:0] TAG_SHIFT = 2'b11;

  // Queue entry is {tag, 2*Width data}
  function automatic int unsigned entry_w(input int unsigned w);
    return 2 * w + 2;
  endfunction

  localparam int unsigned ENTRY_W = 2 * ALU_WIDTH + 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned DataW = 34,
  parameter int unsigned Depth = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DataW-1:0]         din,
  output logic [DataW-1:0]         dout,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;

  logic [DataW-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == CountW'(Depth));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CountW'(wr_en) - CountW'(rd_en);
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the head is only meaningful while not empty
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/alu_result_queue.sv
// Collects the single active ALU unit result each cycle, tags it with its source
// and queues it for a valid/ready consumer; sticky bits flag drops and flag collisions.
module alu_result_queue
  import alu_pkg::*;
#(
  parameter int unsigned Width = ALU_WIDTH,
  parameter int unsigned Depth = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2*Width-1:0]       Arith_OUT,
  input  logic [Width-1:0]         Logic_OUT,
  input  logic [Width-1:0]         CMP_OUT,
  input  logic [Width-1:0]         Shift_OUT,
  input  logic                     Arith_Flag,
  input  logic                     Logic_Flag,
  input  logic                     CMP_Flag,
  input  logic                     Shift_Flag,
  input  logic                     Res_Ready,
  input  logic                     Err_Clr,
  output logic                     Res_Valid,
  output logic [2*Width-1:0]       Res_Data,
  output logic [1:0]               Res_Tag,
  output logic [$clog2(Depth):0]   Count,
  output logic                     Overflow,
  output logic                     Multi_Flag_Err
);

  localparam int unsigned DataW  = 2 * Width;
  localparam int unsigned EntryW = entry_w(Width);

  logic [3:0]        flags;
  logic              single_c;
  logic              multi_c;
  logic [1:0]        tag_c;
  logic [DataW-1:0]  data_c;
  logic [EntryW-1:0] head;
  logic              full;
  logic              empty;
  logic              drop_c;
  logic              ovf_q, ovf_d;
  logic              merr_q, merr_d;

  // Decode the unit flags into one tagged, width-formatted entry
  always_comb begin
    flags    = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    single_c = 1'b1;
    tag_c    = TAG_ARITH;
    data_c   = '0;
    unique case (flags)
      4'b0001: begin tag_c = TAG_ARITH; data_c = Arith_OUT;                  end
      4'b0010: begin tag_c = TAG_LOGIC; data_c = {{Width{1'b0}}, Logic_OUT}; end
      4'b0100: begin tag_c = TAG_CMP;   data_c = {{Width{1'b0}}, CMP_OUT};   end
      4'b1000: begin tag_c = TAG_SHIFT; data_c = {{Width{1'b0}}, Shift_OUT}; end
      default: single_c = 1'b0;
    endcase
    multi_c = ((flags & (flags - 4'd1)) != 4'd0);
  end

  sync_fifo #(
    .DataW (EntryW),
    .Depth (Depth)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (single_c),
    .pop   (Res_Ready),
    .din   ({tag_c, data_c}),
    .dout  (head),
    .count (Count),
    .full  (full),
    .empty (empty)
  );

  assign Res_Valid = !empty;
  assign Res_Data  = Res_Valid ? head[DataW-1:0] : '0;
  assign Res_Tag   = Res_Valid ? head[EntryW-1:DataW] : 2'b00;

  // Sticky errors: a new event on the same edge outranks Err_Clr
  always_comb begin
    drop_c = single_c && full && !Res_Ready;
    ovf_d  = ovf_q;
    merr_d = merr_q;
    if (drop_c)       ovf_d = 1'b1;
    else if (Err_Clr) ovf_d = 1'b0;
    if (multi_c)      merr_d = 1'b1;
    else if (Err_Clr) merr_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q  <= 1'b0;
      merr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      merr_q <= merr_d;
    end
  end

  assign Overflow       = ovf_q;
  assign Multi_Flag_Err = merr_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue: a queue model tracks accepted entries,
// sticky bits and occupancy, and every cycle is compared against the DUT.
module tb_alu_result_queue;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Arith_OUT;
  logic [15:0] Logic_OUT, CMP_OUT, Shift_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic        Res_Ready, Err_Clr;
  logic        Res_Valid;
  logic [31:0] Res_Data;
  logic [1:0]  Res_Tag;
  logic [2:0]  Count;
  logic        Overflow, Multi_Flag_Err;

  logic [33:0] exp_q[$];
  logic        m_ovf, m_merr;
  int          total, passed;

  alu_result_queue #(.Width(16), .Depth(DEPTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Arith_OUT      (Arith_OUT),
    .Logic_OUT      (Logic_OUT),
    .CMP_OUT        (CMP_OUT),
    .Shift_OUT      (Shift_OUT),
    .Arith_Flag     (Arith_Flag),
    .Logic_Flag     (Logic_Flag),
    .CMP_Flag       (CMP_Flag),
    .Shift_Flag     (Shift_Flag),
    .Res_Ready      (Res_Ready),
    .Err_Clr        (Err_Clr),
    .Res_Valid      (Res_Valid),
    .Res_Data       (Res_Data),
    .Res_Tag        (Res_Tag),
    .Count          (Count),
    .Overflow       (Overflow),
    .Multi_Flag_Err (Multi_Flag_Err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else passed++;
  endtask

  function automatic logic [33:0] make_entry(input logic [3:0] f);
    case (f)
      4'b0001: return {2'b00, Arith_OUT};
      4'b0010: return {2'b01, 16'h0000, Logic_OUT};
      4'b0100: return {2'b10, 16'h0000, CMP_OUT};
      default: return {2'b11, 16'h0000, Shift_OUT};
    endcase
  endfunction

  // One clock: update the scoreboard from the driven inputs, then compare outputs
  task automatic step();
    logic [3:0]  f;
    logic [33:0] head;
    bit          do_pop, full, one;
    f = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
    @(posedge CLK);
    if (RST) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_merr = 1'b0;
    end else begin
      do_pop = (exp_q.size() > 0) && Res_Ready;
      full   = (exp_q.size() == DEPTH);
      one    = ($countones(f) == 1);
      if ($countones(f) > 1)         m_merr = 1'b1;
      else if (Err_Clr)              m_merr = 1'b0;
      if (one && full && !Res_Ready) m_ovf = 1'b1;
      else if (Err_Clr)              m_ovf = 1'b0;
      if (do_pop) void'(exp_q.pop_front());
      if (one && (!full || do_pop)) exp_q.push_back(make_entry(f));
    end
    #1;
    check("valid", 64'(Res_Valid), 64'(exp_q.size() != 0));
    check("count", 64'(Count), 64'(exp_q.size()));
    check("overflow", 64'(Overflow), 64'(m_ovf));
    check("multi_err", 64'(Multi_Flag_Err), 64'(m_merr));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("head_data", 64'(Res_Data), 64'(head[31:0]));
      check("head_tag", 64'(Res_Tag), 64'(head[33:32]));
    end else begin
      check("idle_data", 64'(Res_Data), 64'd0);
      check("idle_tag", 64'(Res_Tag), 64'd0);
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag} = f;
  endtask

  initial begin
    total = 0; passed = 0;
    m_ovf = 1'b0; m_merr = 1'b0;
    RST = 1'b1; Err_Clr = 1'b0; Res_Ready = 1'b0;
    Arith_OUT = '0; Logic_OUT = '0; CMP_OUT = '0; Shift_OUT = '0;
    set_flags(4'b0000);

    // Reset with random flags
    for (int i = 0; i < 2; i++) begin
      set_flags(4'($urandom_range(0, 15)));
      Res_Ready = 1'($urandom_range(0, 1));
      Arith_OUT = $urandom;
      step();
    end
    RST = 1'b0; set_flags(4'b0000); Res_Ready = 1'b1;
    step();
    check("post_reset_count", 64'(Count), 64'd0);

    // Single results
    Arith_OUT = 32'hFFFF_FF9C; set_flags(4'b0001);
    step();
    check("arith_valid", 64'(Res_Valid), 64'd1);
    check("arith_tag", 64'(Res_Tag), 64'd0);
    check("arith_data", 64'(Res_Data), 64'hFFFF_FF9C);
    set_flags(4'b0000);
    step();
    check("arith_drained", 64'(Res_Valid), 64'd0);
    Logic_OUT = 16'h00F0; set_flags(4'b0010);
    step();
    check("logic_data", 64'(Res_Data), 64'h0000_00F0);
    check("logic_tag", 64'(Res_Tag), 64'd1);
    set_flags(4'b0000);
    step();

    // Fill and overflow
    Res_Ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      CMP_OUT = 16'(i); set_flags(4'b0100);
      step();
    end
    check("fill_count", 64'(Count), 64'd4);
    check("fill_overflow", 64'(Overflow), 64'd1);
    set_flags(4'b0000); Res_Ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("fill_order", 64'(Res_Data), 64'(i));
      step();
    end
    check("fill_empty", 64'(Count), 64'd0);
    Err_Clr = 1'b1; step(); Err_Clr = 1'b0;
    check("ovf_cleared", 64'(Overflow), 64'd0);

    // Full with simultaneous push and pop
    Res_Ready = 1'b0;
    for (int i = 11; i <= 14; i++) begin
      CMP_OUT = 16'(i); set_flags(4'b0100);
      step();
    end
    Shift_OUT = 16'h8000; set_flags(4'b1000); Res_Ready = 1'b1;
    step();
    check("pp_count", 64'(Count), 64'd4);
    check("pp_overflow", 64'(Overflow), 64'd0);
    set_flags(4'b0000);
    for (int i = 12; i <= 14; i++) begin
      check("pp_older", 64'(Res_Data), 64'(i));
      step();
    end
    check("pp_new_data", 64'(Res_Data), 64'h0000_8000);
    check("pp_new_tag", 64'(Res_Tag), 64'd3);
    step();

    // Multiple flags
    Arith_OUT = 32'h1234_5678; Shift_OUT = 16'h0F0F; set_flags(4'b1001);
    step();
    check("multi_set", 64'(Multi_Flag_Err), 64'd1);
    check("multi_nopush", 64'(Count), 64'd0);
    set_flags(4'b0000); Err_Clr = 1'b1;
    step();
    check("multi_clr", 64'(Multi_Flag_Err), 64'd0);
    set_flags(4'b1001);
    step();
    step();
    check("multi_set_wins", 64'(Multi_Flag_Err), 64'd1);
    set_flags(4'b0000);
    step();
    Err_Clr = 1'b0;

    // Reset mid-operation
    Res_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Logic_OUT = 16'(16'hA0 + i); set_flags(4'b0010);
      step();
    end
    check("mid_count", 64'(Count), 64'd3);
    RST = 1'b1;
    step();
    check("rst_count", 64'(Count), 64'd0);
    check("rst_valid", 64'(Res_Valid), 64'd0);
    RST = 1'b0; set_flags(4'b0000);
    step();
    check("rst_nostore", 64'(Count), 64'd0);

    // Random sustained traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      Arith_OUT = $urandom; Logic_OUT = 16'($urandom);
      CMP_OUT = 16'($urandom); Shift_OUT = 16'($urandom);
      if (r == 0)      set_flags(4'b0000);
      else if (r == 1) set_flags(4'b0101);
      else             set_flags(4'(1 << (r % 4)));
      Res_Ready = 1'($urandom_range(0, 1));
      Err_Clr   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
